// File: rtl/route_pkg.sv
// ---------------------------------------------------------------------------
// route_pkg : opcodes, status codes, FSM encoding and frame layout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package route_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_WRITE  = 4'h1;
   localparam logic [3:0] OP_READ   = 4'h2;
   localparam logic [3:0] OP_COMMIT = 4'h3;
   localparam logic [3:0] OP_CLEAR  = 4'h4;
   localparam logic [3:0] OP_STATUS = 4'h5;

   localparam logic [7:0] ST_OK  = 8'h00;
   localparam logic [7:0] ST_ERR = 8'hEE;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int ADDR_MSB = 11;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;
   localparam int EN_BIT   = 7;
   localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/route_table.sv
// ---------------------------------------------------------------------------
// route_table : shadow and active routing entries with write/commit/clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module route_table
   import route_pkg::*;
#(
   parameter int NUM_OUT = 12,
   parameter int NUM_IN  = 4,
   parameter int SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_i,
   input  logic                     commit_i,
   input  logic                     clear_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [SEL_W-1:0]         wr_sel_i,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   output logic [SEL_W-1:0]         rd_sel_o,
   output logic                     rd_en_o,
   output logic [NUM_OUT*SEL_W-1:0] route_sel_o,
   output logic [NUM_OUT-1:0]       route_en_o
);

   logic [NUM_OUT*SEL_W-1:0] dflt_sel;
   logic [NUM_OUT*SEL_W-1:0] sh_sel_q;
   logic [NUM_OUT*SEL_W-1:0] act_sel_q;
   logic [NUM_OUT-1:0]       sh_en_q;
   logic [NUM_OUT-1:0]       act_en_q;

   // Default routing: output i listens to source (i mod NUM_IN), enabled.
   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dflt
      assign dflt_sel[gi*SEL_W +: SEL_W] = SEL_W'(gi % NUM_IN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_sel_q  <= dflt_sel;
         sh_en_q   <= '1;
         act_sel_q <= dflt_sel;
         act_en_q  <= '1;
      end else begin
         if (clear_i) begin
            sh_sel_q <= dflt_sel;
            sh_en_q  <= '1;
         end else if (wr_i) begin
            for (int i = 0; i < NUM_OUT; i++) begin
               if (wr_addr_i == ADDR_W'(i)) begin
                  sh_sel_q[i*SEL_W +: SEL_W] <= wr_sel_i;
                  sh_en_q[i]                 <= wr_en_i;
               end
            end
         end
         // Whole-table copy in one edge keeps the active set coherent.
         if (commit_i) begin
            act_sel_q <= sh_sel_q;
            act_en_q  <= sh_en_q;
         end
      end
   end

   always_comb begin
      rd_sel_o = '0;
      rd_en_o  = 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (rd_addr_i == ADDR_W'(i)) begin
            rd_sel_o = sh_sel_q[i*SEL_W +: SEL_W];
            rd_en_o  = sh_en_q[i];
         end
      end
   end

   assign route_sel_o = act_sel_q;
   assign route_en_o  = act_en_q;

endmodule

`default_nettype wire

// File: rtl/route_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// route_cfg_ctrl : SPI frame decoder driving the MIDI routing table
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module route_cfg_ctrl
   import route_pkg::*;
#(
   parameter int NUM_OUT = 12,
   parameter int NUM_IN  = 4,
   parameter int SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_valid,
   input  logic [15:0]              frame_data,
   output logic                     resp_load,
   output logic [15:0]              resp_data,
   output logic [NUM_OUT*SEL_W-1:0] route_sel,
   output logic [NUM_OUT-1:0]       route_en,
   output logic                     busy,
   output logic                     err
);

   state_e      state_q, state_d;
   logic [15:0] frame_q, frame_d;
   logic [15:0] resp_q, resp_d;
   logic        err_q, err_d;

   logic                  tbl_wr, tbl_commit, tbl_clear;
   logic [SEL_W-1:0]      rd_sel;
   logic                  rd_en;
   logic [7:0]            status;
   logic                  cmd_err;

   logic [3:0]            op;
   logic [ADDR_W-1:0]     addr;
   logic [7:0]            data;
   logic                  addr_bad;
   logic                  sel_bad;

   assign op   = frame_q[OP_MSB:OP_LSB];
   assign addr = frame_q[ADDR_MSB:ADDR_LSB];
   assign data = frame_q[DATA_MSB:DATA_LSB];

   assign addr_bad = int'(addr) >= NUM_OUT;
   assign sel_bad  = int'(data[SEL_W-1:0]) >= NUM_IN;

   // Middle data bits carry no meaning on WRITE.
   logic unused_data;
   assign unused_data = ^data[EN_BIT-1:SEL_W];

   route_table #(
      .NUM_OUT (NUM_OUT),
      .NUM_IN  (NUM_IN),
      .SEL_W   (SEL_W)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .wr_i        (tbl_wr),
      .commit_i    (tbl_commit),
      .clear_i     (tbl_clear),
      .wr_addr_i   (addr),
      .wr_sel_i    (data[SEL_W-1:0]),
      .wr_en_i     (data[EN_BIT]),
      .rd_addr_i   (addr),
      .rd_sel_o    (rd_sel),
      .rd_en_o     (rd_en),
      .route_sel_o (route_sel),
      .route_en_o  (route_en)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         frame_q <= '0;
         resp_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      resp_d     = resp_q;
      err_d      = err_q;
      tbl_wr     = 1'b0;
      tbl_commit = 1'b0;
      tbl_clear  = 1'b0;
      status     = ST_OK;
      cmd_err    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (frame_valid) begin
               frame_d = frame_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_RESP;
            case (op)
               OP_NOP: ;
               OP_WRITE: begin
                  if (addr_bad || sel_bad) cmd_err = 1'b1;
                  else                     tbl_wr  = 1'b1;
               end
               OP_READ: begin
                  if (addr_bad) cmd_err = 1'b1;
                  else          status  = {rd_en, 7'(rd_sel)};
               end
               OP_COMMIT: tbl_commit = 1'b1;
               OP_CLEAR:  tbl_clear  = 1'b1;
               OP_STATUS: begin
                  status = {7'b0, err_q};
                  err_d  = 1'b0;
               end
               default: cmd_err = 1'b1;
            endcase
            if (cmd_err) begin
               status = ST_ERR;
               err_d  = 1'b1;
            end
            resp_d = {op, addr, status};
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Overrun set wins over a STATUS clear in the same cycle.
      if (frame_valid && (state_q != S_IDLE)) err_d = 1'b1;
   end

   assign resp_load = (state_q == S_RESP);
   assign resp_data = resp_q;
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_route_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_route_cfg_ctrl : directed and randomized checks against a table model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_route_cfg_ctrl;

   localparam int NUM_OUT = 12;
   localparam int NUM_IN  = 4;
   localparam int SEL_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     frame_valid;
   logic [15:0]              frame_data;
   logic                     resp_load;
   logic [15:0]              resp_data;
   logic [NUM_OUT*SEL_W-1:0] route_sel;
   logic [NUM_OUT-1:0]       route_en;
   logic                     busy;
   logic                     err;

   int n_checks = 0;
   int n_errors = 0;

   route_cfg_ctrl #(.NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .resp_load   (resp_load),
      .resp_data   (resp_data),
      .route_sel   (route_sel),
      .route_en    (route_en),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays of source numbers and enables.
   int m_sh_sel  [NUM_OUT];
   int m_act_sel [NUM_OUT];
   bit m_sh_en   [NUM_OUT];
   bit m_act_en  [NUM_OUT];
   bit m_err;

   typedef struct {
      logic                     load1, busy1;
      logic                     load2;
      logic [15:0]              resp;
      logic [NUM_OUT*SEL_W-1:0] sel;
      logic [NUM_OUT-1:0]       en;
      logic                     err2;
      logic                     load3, busy3, err3;
   } obs_t;

   task automatic model_reset();
      for (int i = 0; i < NUM_OUT; i++) begin
         m_sh_sel[i]  = i % NUM_IN;
         m_sh_en[i]   = 1'b1;
         m_act_sel[i] = i % NUM_IN;
         m_act_en[i]  = 1'b1;
      end
      m_err = 1'b0;
   endtask

   task automatic model_cmd(input logic [15:0] f, output logic [15:0] resp);
      int         op   = int'(f[15:12]);
      int         addr = int'(f[11:8]);
      int         src  = int'(f[1:0]);
      logic [7:0] st   = 8'h00;
      bit         bad  = 1'b0;
      case (op)
         0: ;
         1: begin
            if (addr >= NUM_OUT || src >= NUM_IN) bad = 1'b1;
            else begin
               m_sh_sel[addr] = src;
               m_sh_en[addr]  = f[7];
            end
         end
         2: begin
            if (addr >= NUM_OUT) bad = 1'b1;
            else st = {m_sh_en[addr], 7'(m_sh_sel[addr])};
         end
         3: for (int i = 0; i < NUM_OUT; i++) begin
               m_act_sel[i] = m_sh_sel[i];
               m_act_en[i]  = m_sh_en[i];
            end
         4: for (int i = 0; i < NUM_OUT; i++) begin
               m_sh_sel[i] = i % NUM_IN;
               m_sh_en[i]  = 1'b1;
            end
         5: begin
            st    = {7'b0, m_err};
            m_err = 1'b0;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         st    = 8'hEE;
         m_err = 1'b1;
      end
      resp = {f[15:8], st};
   endtask

   function automatic logic [NUM_OUT*SEL_W-1:0] exp_sel();
      logic [NUM_OUT*SEL_W-1:0] r;
      for (int i = 0; i < NUM_OUT; i++) r[i*SEL_W +: SEL_W] = SEL_W'(m_act_sel[i]);
      return r;
   endfunction

   function automatic logic [NUM_OUT-1:0] exp_en();
      logic [NUM_OUT-1:0] r;
      for (int i = 0; i < NUM_OUT; i++) r[i] = m_act_en[i];
      return r;
   endfunction

   // Drives one frame (ovr: 0 none, 1 extra pulse in EXEC, 2 in RESP) and
   // samples the three following cycles; the model is stepped alongside.
   task automatic do_frame(input logic [15:0] f, input int ovr, output obs_t o,
                           output logic [15:0] e_resp, output logic e_err2,
                           output logic e_err3);
      model_cmd(f, e_resp);
      e_err2 = m_err | (ovr == 1);
      if (ovr != 0) m_err = 1'b1;
      e_err3 = m_err;

      frame_data  = f;
      frame_valid = 1'b1;
      @(posedge clk); #1;
      o.load1     = resp_load;
      o.busy1     = busy;
      frame_valid = (ovr == 1);
      frame_data  = 16'($urandom);
      @(posedge clk); #1;
      o.load2     = resp_load;
      o.resp      = resp_data;
      o.sel       = route_sel;
      o.en        = route_en;
      o.err2      = err;
      frame_valid = (ovr == 2);
      @(posedge clk); #1;
      frame_valid = 1'b0;
      o.load3     = resp_load;
      o.busy3     = busy;
      o.err3      = err;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      frame_valid = 1'b0;
      frame_data  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (route_sel !== 24'hE4E4E4) begin
         n_errors++;
         $display("FAIL reset_sel: got %h want %h", route_sel, 24'hE4E4E4);
      end
      n_checks++;
      if (route_en !== 12'hFFF) begin
         n_errors++;
         $display("FAIL reset_en: got %h want fff", route_en);
      end
      n_checks++;
      if ({resp_load, busy, err} !== 3'b000 || resp_data !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_ctl: load/busy/err=%b resp=%h want 000/0000",
                  {resp_load, busy, err}, resp_data);
      end
   endtask

   task automatic test_write_read();
      obs_t o; logic [15:0] er; logic e2, e3;
      do_frame(16'h1502, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h1500 || er !== 16'h1500) begin
         n_errors++;
         $display("FAIL write_resp: got %h want 1500", o.resp);
      end
      n_checks++;
      if ({o.load1, o.load2, o.load3} !== 3'b010) begin
         n_errors++;
         $display("FAIL write_latency: load N+1..N+3=%b want 010", {o.load1, o.load2, o.load3});
      end
      do_frame(16'h2500, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h2502 || er !== 16'h2502) begin
         n_errors++;
         $display("FAIL read_resp: got %h want 2502", o.resp);
      end
      n_checks++;
      if (o.sel !== 24'hE4E4E4 || o.en !== 12'hFFF) begin
         n_errors++;
         $display("FAIL write_no_active: sel=%h en=%h want e4e4e4/fff", o.sel, o.en);
      end
   endtask

   task automatic test_commit();
      obs_t o; logic [15:0] er; logic e2, e3;
      do_frame(16'h3000, 0, o, er, e2, e3);
      n_checks++;
      if (o.sel[11:10] !== 2'd2 || o.en[5] !== 1'b0) begin
         n_errors++;
         $display("FAIL commit_out5: sel=%0d en=%b want 2/0", o.sel[11:10], o.en[5]);
      end
      n_checks++;
      if (o.sel !== exp_sel() || o.en !== exp_en() || o.sel !== 24'hE4E8E4) begin
         n_errors++;
         $display("FAIL commit_table: sel=%h en=%h want %h/%h", o.sel, o.en, exp_sel(), exp_en());
      end
      n_checks++;
      if (o.resp !== 16'h3000) begin
         n_errors++;
         $display("FAIL commit_resp: got %h want 3000", o.resp);
      end
   endtask

   task automatic test_errors();
      obs_t o; logic [15:0] er; logic e2, e3;
      do_frame(16'h1C81, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h1CEE || o.err2 !== 1'b1) begin
         n_errors++;
         $display("FAIL bad_addr: resp=%h err=%b want 1cee/1", o.resp, o.err2);
      end
      do_frame(16'h9000, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h90EE || o.err2 !== 1'b1) begin
         n_errors++;
         $display("FAIL bad_op: resp=%h err=%b want 90ee/1", o.resp, o.err2);
      end
      n_checks++;
      if (o.sel !== exp_sel() || o.en !== exp_en()) begin
         n_errors++;
         $display("FAIL err_no_change: sel=%h en=%h want %h/%h", o.sel, o.en, exp_sel(), exp_en());
      end
      do_frame(16'h5000, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h5001 || o.err2 !== 1'b0) begin
         n_errors++;
         $display("FAIL status1: resp=%h err=%b want 5001/0", o.resp, o.err2);
      end
      do_frame(16'h5000, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h5000) begin
         n_errors++;
         $display("FAIL status2: resp=%h want 5000", o.resp);
      end
   endtask

   task automatic test_overrun();
      obs_t o; logic [15:0] er; logic e2, e3;
      do_frame(16'h1301, 1, o, er, e2, e3);
      n_checks++;
      if ({o.load1, o.load2, o.load3} !== 3'b010 || o.err2 !== 1'b1 || o.resp !== 16'h1300) begin
         n_errors++;
         $display("FAIL overrun: loads=%b err=%b resp=%h want 010/1/1300",
                  {o.load1, o.load2, o.load3}, o.err2, o.resp);
      end
      do_frame(16'h5000, 1, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h5001 || o.err2 !== 1'b1) begin
         n_errors++;
         $display("FAIL status_vs_overrun: resp=%h err=%b want 5001/1", o.resp, o.err2);
      end
      do_frame(16'h5000, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h5001 || o.err2 !== 1'b0) begin
         n_errors++;
         $display("FAIL status_after_overrun: resp=%h err=%b want 5001/0", o.resp, o.err2);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o; logic [15:0] er; logic e2, e3;
      do_frame(16'h1083, 0, o, er, e2, e3);
      do_frame(16'h3000, 0, o, er, e2, e3);
      n_checks++;
      if (o.sel[1:0] !== 2'd3 || o.sel !== exp_sel() || o.en !== exp_en()) begin
         n_errors++;
         $display("FAIL b2b_commit: sel=%h en=%h want %h/%h", o.sel, o.en, exp_sel(), exp_en());
      end
      do_frame(16'h2000, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h2083) begin
         n_errors++;
         $display("FAIL b2b_read: resp=%h want 2083", o.resp);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o; logic [15:0] er; logic e2, e3;
      do_frame(16'h1A00, 0, o, er, e2, e3);
      frame_data  = 16'h3000;
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      reset       = 1'b1;
      @(posedge clk); #1;
      model_reset();
      n_checks++;
      if (resp_load !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_ctl: load=%b busy=%b err=%b want 0/0/0", resp_load, busy, err);
      end
      n_checks++;
      if (route_sel !== 24'hE4E4E4 || route_en !== 12'hFFF) begin
         n_errors++;
         $display("FAIL reset_mid_tbl: sel=%h en=%h want e4e4e4/fff", route_sel, route_en);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (resp_load !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_noload: load=%b want 0", resp_load);
      end
      do_frame(16'h2A00, 0, o, er, e2, e3);
      n_checks++;
      if (o.resp !== 16'h2A82 || o.resp !== er) begin
         n_errors++;
         $display("FAIL reset_mid_shadow: resp=%h want 2a82", o.resp);
      end
   endtask

   task automatic test_random();
      obs_t o; logic [15:0] er; logic e2, e3; logic [15:0] f;
      int ovr;
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: f[15:12] = 4'h1;
            3, 4:    f[15:12] = 4'h2;
            5:       f[15:12] = 4'h3;
            6:       f[15:12] = 4'h4;
            7:       f[15:12] = 4'h5;
            8:       f[15:12] = 4'h0;
            default: f[15:12] = 4'($urandom_range(6, 15));
         endcase
         f[11:8] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, NUM_OUT - 1))
                                             : 4'($urandom_range(NUM_OUT, 15));
         f[7:0]  = 8'($urandom);
         ovr     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         do_frame(f, ovr, o, er, e2, e3);
         n_checks++;
         if (o.resp !== er) begin
            n_errors++;
            $display("FAIL rnd_resp[%0d] f=%h: got %h want %h", n, f, o.resp, er);
         end
         n_checks++;
         if (o.sel !== exp_sel() || o.en !== exp_en()) begin
            n_errors++;
            $display("FAIL rnd_table[%0d] f=%h: sel=%h en=%h want %h/%h",
                     n, f, o.sel, o.en, exp_sel(), exp_en());
         end
         n_checks++;
         if ({o.load1, o.load2, o.load3, o.busy1, o.busy3} !== 5'b01010) begin
            n_errors++;
            $display("FAIL rnd_timing[%0d]: load/busy=%b want 01010", n,
                     {o.load1, o.load2, o.load3, o.busy1, o.busy3});
         end
         n_checks++;
         if (o.err2 !== e2 || o.err3 !== e3) begin
            n_errors++;
            $display("FAIL rnd_err[%0d] f=%h ovr=%0d: err=%b%b want %b%b",
                     n, f, ovr, o.err2, o.err3, e2, e3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_commit();
      test_errors();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
